mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit, between the EX/MEM register and the MEM/WB register.
- Turns load/store control plus address/store data into a request/grant/response data-bus transaction.
- Aligns and sign/zero-extends load data into mem_data_out_mem.
- Raises stall_mem so the hazard unit drops enable on the upstream pipeline registers.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles waiting for gnt or rvalid before bus_err; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- mem_read_ctrl_mem  in  1  load in MEM stage
- mem_write_ctrl_mem  in  1  store in MEM stage
- mem_width_mem  in  3  funct3: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101
- alu_result_mem  in  32  byte address
- rs2_data_mem  in  32  store data
- pipe_hold  in  1  downstream stall; holds the DONE state
- bus_req  out  1  request valid
- bus_we  out  1  1 = write
- bus_addr  out  32  word address ({alu_result_mem[31:2],2'b00})
- bus_wdata  out  32  store data replicated to lanes
- bus_be  out  4  byte enables
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read word
- mem_data_out_mem  out  32  extended load data to MEM/WB
- stall_mem  out  1  freeze IF..EX/MEM
- misaligned_err  out  1  one-cycle pulse on a misaligned access
- bus_err  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset: synchronous. While rst_n=0 every output is 0. At the edge the state goes to IDLE and the counter and load register clear. Reset mid-transaction abandons it with no completion and no error; a later rvalid in IDLE is ignored.
- access = read|write. If both are set, read wins.
- Alignment: H requires addr[0]=0; W requires addr[1:0]=0; B is always aligned.
- Misaligned access in IDLE: no bus_req, stall_mem=0, misaligned_err=1 for that cycle, mem_data_out_mem=0. The instruction passes on the next edge.
- bus_be: B = 1<<addr[1:0]; H = 0011 or 1100 by addr[1]; W = 1111. Loads drive the same be.
- bus_wdata: B = {4{rs2[7:0]}}; H = {2{rs2[15:0]}}; W = rs2.
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE: an aligned access drives bus_req=1 combinationally and stall_mem=1. With gnt the FSM goes to RESP for a read or DONE for a write; without gnt it goes to REQ.
  - REQ: bus_req=1 and stall_mem=1, with address, be and data held stable. On gnt it goes to RESP for a read or DONE for a write.
  - RESP: bus_req=0, stall_mem=1. On rvalid the extracted load data is captured into load_q and the FSM goes to DONE.
  - DONE: stall_mem=0, mem_data_out_mem=load_q (0 for stores). Goes to IDLE unless pipe_hold=1, in which case it stays in DONE.
- Minimum latency: a read with gnt at t0 and rvalid at t1 reaches DONE at t2, so stall_mem is high for 2 cycles. A write granted at t0 gives 1 stall cycle.
- gnt and rvalid in the same cycle while in IDLE or REQ: rvalid is ignored; the response is taken in RESP.
- Load extraction: the byte/halfword is selected by addr[1:0] / addr[1]. LB/LH sign-extend, LBU/LHU zero-extend.
- Watchdog: the counter clears on entry to REQ or RESP and increments each cycle spent there. Expiry while waiting for gnt or rvalid, at TIMEOUT_CYCLES-1 with no event, does the following:
  - pulses bus_err;
  - goes to DONE with load_q=0.
- IDLE with no access: bus_req=0, stall_mem=0, mem_data_out_mem=0.

Decomposition:
- Add the following to control_types_pkg:
  - mem_width_t enum with the funct3 encodings above;
  - mem_state_t enum {IDLE, REQ, RESP, DONE}.
- One sub-module: mem_load_extract. It is combinational and takes rdata, addr[1:0] and width to produce the 32-bit extended value. It is reused by any future cache path.

Test Plan:
- Reset: rst_n=0 for 2 cycles with a pending LW → all outputs 0, state IDLE. Raise rst_n with no access → bus_req=0.
- LB at addr 0x103, memory returns 0x80FFFFFF after gnt at t0 and rvalid at t1 → bus_be=1000, stall_mem=1 for 2 cycles, mem_data_out_mem=0xFFFFFF80 in DONE.
- SH at 0x202 with rs2=0x1234ABCD, gnt delayed 3 cycles → bus_be=1100, bus_wdata=0xABCDABCD held stable, stall_mem=1 for 4 cycles, then DONE with output 0.
- LW at 0x101 → misaligned_err=1 for one cycle, no bus_req, stall_mem=0. LHU at 0x102 with rdata 0xBEEF0000 → 0x0000BEEF.
- TIMEOUT_CYCLES=4, LW granted but rvalid never arrives → bus_err pulses once, output 0, stall released.
- LW completes into DONE with pipe_hold=1 for 3 cycles → stays DONE, output stable, stall_mem=0. rst_n asserted during RESP, then a late rvalid → ignored, state IDLE.

Source files
------------

// File: rtl/control_types_pkg.sv
// Shared control encodings for the MEM-stage data-memory access path.
`default_nettype none

package control_types_pkg;

  typedef enum logic [2:0] {
    MW_B  = 3'b000,
    MW_H  = 3'b001,
    MW_W  = 3'b010,
    MW_BU = 3'b100,
    MW_HU = 3'b101
  } mem_width_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_load_extract.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
`default_nettype none

module mem_load_extract
  import control_types_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  mem_width_t  width,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (width)
      MW_B:    ext = {{24{byte_sel[7]}}, byte_sel};
      MW_BU:   ext = {24'h0, byte_sel};
      MW_H:    ext = {{16{half_sel[15]}}, half_sel};
      MW_HU:   ext = {16'h0, half_sel};
      default: ext = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: drives a req/gnt/rvalid bus, extends load
// data, stalls the upstream pipeline and flags misalignment and bus timeouts.
`default_nettype none

module mem_access_unit
  import control_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_ctrl_mem,
  input  logic        mem_write_ctrl_mem,
  input  logic [2:0]  mem_width_mem,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] rs2_data_mem,
  input  logic        pipe_hold,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic [31:0] mem_data_out_mem,
  output logic        stall_mem,
  output logic        misaligned_err,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic WD_EN = (TIMEOUT_CYCLES != 0);

  mem_state_t  state;
  logic [CW-1:0] cnt;
  logic [31:0] load_q;

  mem_width_t  width;
  logic        access;
  logic        is_byte;
  logic        is_half;
  logic        aligned;
  logic        wd_last;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] load_ext;

  assign width   = mem_width_t'(mem_width_mem);
  assign access  = mem_read_ctrl_mem | mem_write_ctrl_mem;
  assign is_byte = (mem_width_mem[1:0] == 2'b00);
  assign is_half = (mem_width_mem[1:0] == 2'b01);
  assign aligned = is_byte | (is_half & ~alu_result_mem[0])
                 | (~is_byte & ~is_half & (alu_result_mem[1:0] == 2'b00));
  assign wd_last = WD_EN && (cnt == LAST);

  always_comb begin
    if (is_byte) begin
      be_calc    = 4'b0001 << alu_result_mem[1:0];
      wdata_calc = {4{rs2_data_mem[7:0]}};
    end else if (is_half) begin
      be_calc    = alu_result_mem[1] ? 4'b1100 : 4'b0011;
      wdata_calc = {2{rs2_data_mem[15:0]}};
    end else begin
      be_calc    = 4'b1111;
      wdata_calc = rs2_data_mem;
    end
  end

  mem_load_extract u_extract (
    .rdata   (bus_rdata),
    .addr_lo (alu_result_mem[1:0]),
    .width   (width),
    .ext     (load_ext)
  );

  // Outputs are decoded from state and the (stalled, hence stable) MEM-stage inputs.
  always_comb begin
    bus_req          = 1'b0;
    stall_mem        = 1'b0;
    misaligned_err   = 1'b0;
    bus_err          = 1'b0;
    mem_data_out_mem = 32'h0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (access && aligned) begin
            bus_req   = 1'b1;
            stall_mem = 1'b1;
          end else if (access) begin
            misaligned_err = 1'b1;
          end
        end
        REQ: begin
          bus_req   = 1'b1;
          stall_mem = 1'b1;
          bus_err   = wd_last && !bus_gnt;
        end
        RESP: begin
          stall_mem = 1'b1;
          bus_err   = wd_last && !bus_rvalid;
        end
        DONE: mem_data_out_mem = load_q;
        default: ;
      endcase
    end
    bus_we    = bus_req & ~mem_read_ctrl_mem;
    bus_addr  = bus_req ? {alu_result_mem[31:2], 2'b00} : 32'h0;
    bus_be    = bus_req ? be_calc : 4'h0;
    bus_wdata = bus_req ? wdata_calc : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      load_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (access && aligned) begin
            cnt <= '0;
            if (!bus_gnt) begin
              state <= REQ;
            end else if (mem_read_ctrl_mem) begin
              state <= RESP;
            end else begin
              state  <= DONE;
              load_q <= 32'h0;
            end
          end
        end
        REQ: begin
          if (bus_gnt) begin
            cnt <= '0;
            if (mem_read_ctrl_mem) begin
              state <= RESP;
            end else begin
              state  <= DONE;
              load_q <= 32'h0;
            end
          end else if (wd_last) begin
            state  <= DONE;
            load_q <= 32'h0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus_rvalid) begin
            state  <= DONE;
            load_q <= load_ext;
          end else if (wd_last) begin
            state  <= DONE;
            load_q <= 32'h0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (!pipe_hold) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
